// File: rtl/pipelined_mul_hs.sv
// pipelined_mul_hs: parameterised shift-add pipelined multiplier.
// B multiplier bits are retired per stage over S = M/B stages. Each operation
// selects signed or unsigned arithmetic. Input and output use a valid/ready
// handshake, and a stall freezes the whole pipeline.
module pipelined_mul_hs #(
    parameter int N     = 16,
    parameter int M     = 16,
    parameter int B     = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     multiplicand,
    input  logic [M-1:0]     multiplier,
    input  logic             signed_mode,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   Product,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);
    localparam int S = M / B;
    localparam int P = N + M;

    logic [S-1:0]            vld_q,   vld_d;
    logic [S-1:0][P-1:0]     acc_q,   acc_d;
    logic [S-1:0][N-1:0]     mcand_q, mcand_d;
    logic [S-1:0][M-1:0]     mrem_q,  mrem_d;   // multiplier bits not yet retired
    logic [S-1:0]            mode_q,  mode_d;
    logic [S-1:0][TAG_W-1:0] tag_q,   tag_d;
    logic                    advance;

    // Partial product of one B-bit digit, before it is shifted to its weight.
    // In signed mode the digit MSB of the final stage has negative weight.
    function automatic logic [P-1:0] digit_pp(
        input logic [N-1:0] a,
        input logic [B-1:0] digit,
        input logic         sgn,
        input logic         msb_neg
    );
        logic [P-1:0] a_ext;
        logic [P-1:0] pp;
        a_ext = sgn ? {{M{a[N-1]}}, a} : {{M{1'b0}}, a};
        pp    = a_ext * P'(digit);
        if (sgn && msb_neg && digit[B-1]) begin
            pp = pp - (a_ext << B);
        end
        return pp;
    endfunction

    // One global enable: the pipeline moves only when the output slot is
    // empty or is being drained in this cycle.
    assign advance   = !vld_q[S-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[S-1];
    assign Product   = acc_q[S-1];
    assign tag_out   = tag_q[S-1];
    assign busy      = |vld_q;

    // The final stage's operand copies have no consumer. This folds them into a
    // deliberately unused net so the intent stays visible.
    logic unused_last_stage;
    assign unused_last_stage = ^{mcand_q[S-1], mrem_q[S-1], mode_q[S-1]};

    // Next state of every stage: hold on stall, otherwise shift by one stage.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        vld_d   = vld_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mrem_d  = mrem_q;
        mode_d  = mode_q;
        tag_d   = tag_q;
        if (advance) begin
            vld_d[0]   = in_valid;
            acc_d[0]   = digit_pp(multiplicand, multiplier[B-1:0], signed_mode, S == 1);
            mcand_d[0] = multiplicand;
            mrem_d[0]  = multiplier >> B;
            mode_d[0]  = signed_mode;
            tag_d[0]   = tag_in;
            for (int k = 1; k < S; k++) begin
                vld_d[k]   = vld_q[k-1];
                acc_d[k]   = acc_q[k-1]
                           + (digit_pp(mcand_q[k-1], mrem_q[k-1][B-1:0], mode_q[k-1], k == S - 1)
                              << (k * B));
                mcand_d[k] = mcand_q[k-1];
                mrem_d[k]  = mrem_q[k-1] >> B;
                mode_d[k]  = mode_q[k-1];
                tag_d[k]   = tag_q[k-1];
            end
        end
    end

    // Stage registers. Reset discards in-flight work and zeroes the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are reset as well as the valid bits, so Product and tag_out read 0 out of reset.
            vld_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mrem_q  <= '0;
            mode_q  <= '0;
            tag_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make all stages update together from the old values.
            vld_q   <= vld_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mrem_q  <= mrem_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_pipelined_mul_hs.sv
// Directed bench for pipelined_mul_hs: a 16x16 radix-2 instance and an
// 8x12 radix-16 instance.
module tb_pipelined_mul_hs;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy, signed_mode;
    logic [15:0] multiplicand, multiplier;
    logic [3:0]  tag_in, tag_out;
    logic [31:0] Product;

    logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_busy, r_signed;
    logic [7:0]  r_mcand;
    logic [11:0] r_mplier;
    logic [3:0]  r_tag_in, r_tag_out;
    logic [19:0] r_product;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] prod;
        logic [3:0]  tag;
    } exp_t;

    pipelined_mul_hs #(.N(16), .M(16), .B(1), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand(multiplicand), .multiplier(multiplier), .signed_mode(signed_mode),
        .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
        .Product(Product), .tag_out(tag_out), .busy(busy)
    );

    pipelined_mul_hs #(.N(8), .M(12), .B(4), .TAG_W(4)) dut_r (
        .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .multiplicand(r_mcand), .multiplier(r_mplier), .signed_mode(r_signed),
        .tag_in(r_tag_in), .out_valid(r_out_valid), .out_ready(r_out_ready),
        .Product(r_product), .tag_out(r_tag_out), .busy(r_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product, computed with wide integer arithmetic.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint x, y;
        logic [63:0] r;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        r = 64'(x * y);
        return r[31:0];
    endfunction

    // Issue one operation to the 16x16 DUT and wait for its result.
    // Entered and left at 1 time unit after a rising edge.
    task automatic issue_one(input logic [15:0] a, input logic [15:0] b, input logic s,
                             input logic [3:0] t, output logic [31:0] p,
                             output logic [3:0] to, output int lat);
        multiplicand = a; multiplier = b; signed_mode = s; tag_in = t;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p = Product; to = tag_out;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1; in_valid = 1'b0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL drain: busy=%b required 0", busy); end
    endtask

    task automatic test_reset();
        #12;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset out_valid: %b required 0", out_valid); end
        tests_run++; if (Product !== 32'h0) begin tests_failed++; $display("FAIL reset Product: %h required 0", Product); end
        tests_run++; if (tag_out !== 4'h0) begin tests_failed++; $display("FAIL reset tag_out: %h required 0", tag_out); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: %b required 0", busy); end
        tests_run++; if (r_out_valid !== 1'b0 || r_product !== 20'h0) begin tests_failed++; $display("FAIL reset radix dut: out_valid=%b Product=%h required 0/0", r_out_valid, r_product); end
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset in_ready: %b required 1", in_ready); end
    endtask

    task automatic test_unsigned();
        logic [31:0] p;
        logic [3:0]  t;
        int          lat;
        issue_one(16'hFFFF, 16'hFFFF, 1'b0, 4'h3, p, t, lat);
        tests_run++; if (lat !== 15) begin tests_failed++; $display("FAIL unsigned latency: %0d edges required 15", lat); end
        tests_run++; if (p !== 32'hFFFE0001) begin tests_failed++; $display("FAIL unsigned max: %h required FFFE0001", p); end
        tests_run++; if (t !== 4'h3) begin tests_failed++; $display("FAIL unsigned tag: %h required 3", t); end
        issue_one(16'h1234, 16'h0000, 1'b0, 4'hC, p, t, lat);
        tests_run++; if (p !== 32'h0 || t !== 4'hC) begin tests_failed++; $display("FAIL unsigned zero: %h/%h required 00000000/c", p, t); end
    endtask

    task automatic test_signed();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [31:0] vp [4];
        logic [31:0] p;
        logic [3:0]  t;
        int          lat;
        va = '{16'hFFFF, 16'h8000, 16'h8000, 16'h0003};
        vb = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFE};
        vp = '{32'h00000001, 32'h40000000, 32'hC0008000, 32'hFFFFFFFA};
        for (int i = 0; i < 4; i++) begin
            issue_one(va[i], vb[i], 1'b1, 4'(i + 8), p, t, lat);
            tests_run++; if (p !== vp[i] || t !== 4'(i + 8) || lat !== 15) begin
                tests_failed++; $display("FAIL signed vec%0d: %h tag %h lat %0d required %h tag %h lat 15", i, p, t, lat, vp[i], 4'(i + 8));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [20];
        logic [15:0] vb [20];
        exp_t        q[$];
        exp_t        e;
        int          issued, consumed, first_c, last_c;
        issued = 0; consumed = 0; first_c = -1; last_c = -1;
        for (int i = 0; i < 20; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && consumed < 20; cyc++) begin
            in_valid = (issued < 20);
            if (issued < 20) begin
                multiplicand = va[issued]; multiplier = vb[issued];
                signed_mode = 1'(issued % 2); tag_in = 4'(issued % 16);
            end
            #1;
            if (in_valid) begin
                tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b in_ready op%0d: %b required 1", issued, in_ready); end
            end
            if (in_valid && in_ready) begin
                e.prod = ref_mul(multiplicand, multiplier, signed_mode);
                e.tag  = tag_in;
                q.push_back(e);
                issued++;
            end
            if (out_valid) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++; $display("FAIL b2b unexpected output: %h required none", Product);
                end else begin
                    e = q.pop_front();
                    if (Product !== e.prod || tag_out !== e.tag) begin
                        tests_failed++; $display("FAIL b2b result %0d: %h tag %h required %h tag %h", consumed, Product, tag_out, e.prod, e.tag);
                    end
                end
                consumed++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests_run++; if (consumed !== 20) begin tests_failed++; $display("FAIL b2b count: %0d results required 20", consumed); end
        tests_run++; if (last_c - first_c !== 19) begin tests_failed++; $display("FAIL b2b spacing: span %0d required 19", last_c - first_c); end
    endtask

    task automatic test_stall();
        exp_t        q[$];
        exp_t        e;
        int          issued, consumed, stall_left;
        bit          stalled;
        logic [31:0] hp;
        logic [3:0]  ht;
        issued = 0; consumed = 0; stall_left = 0; stalled = 0; hp = '0; ht = '0;
        for (int cyc = 0; cyc < 120 && consumed < 12; cyc++) begin
            if (!stalled && out_valid) begin
                stalled = 1; stall_left = 5; hp = Product; ht = tag_out;
            end
            out_ready = (stall_left == 0);
            in_valid  = (issued < 12);
            multiplicand = 16'(issued * 4951 + 3);
            multiplier   = 16'(65520 - issued * 529);
            signed_mode  = 1'(issued % 2);
            tag_in       = 4'(issued + 1);
            #1;
            if (stall_left > 0) begin
                tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall in_ready: %b required 0", in_ready); end
                if (stall_left < 5) begin
                    tests_run++; if (out_valid !== 1'b1 || Product !== hp || tag_out !== ht) begin
                        tests_failed++; $display("FAIL stall hold: v=%b %h tag %h required 1 %h tag %h", out_valid, Product, tag_out, hp, ht);
                    end
                end
                stall_left--;
            end
            if (in_valid && in_ready) begin
                e.prod = ref_mul(multiplicand, multiplier, signed_mode);
                e.tag  = tag_in;
                q.push_back(e);
                issued++;
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++; $display("FAIL stall unexpected output: %h required none", Product);
                end else begin
                    e = q.pop_front();
                    if (Product !== e.prod || tag_out !== e.tag) begin
                        tests_failed++; $display("FAIL stall result %0d: %h tag %h required %h tag %h", consumed, Product, tag_out, e.prod, e.tag);
                    end
                end
                consumed++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1; in_valid = 1'b0;
        tests_run++; if (consumed !== 12 || q.size() !== 0 || !stalled) begin
            tests_failed++; $display("FAIL stall totals: consumed %0d left %0d stalled %0d required 12 0 1", consumed, q.size(), stalled);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] p;
        logic [3:0]  t;
        int          lat, n;
        bit          seen;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            multiplicand = 16'(16'h1111 * (i + 1)); multiplier = 16'h0003;
            signed_mode = 1'b0; tag_in = 4'(i + 1); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++; if (out_valid !== 1'b1 || busy !== 1'b1 || Product !== 32'h3333) begin
            tests_failed++; $display("FAIL pre-reset: v=%b busy=%b %h required 1 1 00003333", out_valid, busy, Product);
        end
        #2; rst = 1'b1; #1;
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL async reset flags: v=%b busy=%b required 0 0", out_valid, busy); end
        tests_run++; if (Product !== 32'h0 || tag_out !== 4'h0) begin tests_failed++; $display("FAIL async reset data: %h tag %h required 0 0", Product, tag_out); end
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (in_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL post-reset: in_ready=%b busy=%b required 1 0", in_ready, busy); end
        issue_one(16'd5, 16'd7, 1'b0, 4'hA, p, t, lat);
        tests_run++; if (p !== 32'd35 || t !== 4'hA || lat !== 15) begin
            tests_failed++; $display("FAIL post-reset op: %0d tag %h lat %0d required 35 tag a lat 15", p, t, lat);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL stale result after reset: seen=%b required 0", seen); end
    endtask

    task automatic test_radix();
        logic [7:0]  ra [2];
        logic [11:0] rb [2];
        logic        rs [2];
        logic [19:0] rp [2];
        int          lat;
        ra = '{8'h80, 8'hFF};
        rb = '{12'h800, 12'hFFF};
        rs = '{1'b1, 1'b0};
        rp = '{20'h40000, 20'hFEF01};
        r_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tests_run++; if (r_in_ready !== 1'b1) begin tests_failed++; $display("FAIL radix in_ready vec%0d: %b required 1", i, r_in_ready); end
            r_mcand = ra[i]; r_mplier = rb[i]; r_signed = rs[i]; r_tag_in = 4'(i + 5); r_in_valid = 1'b1;
            @(posedge clk); #1;
            r_in_valid = 1'b0;
            lat = 0;
            while (!r_out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            tests_run++; if (r_product !== rp[i] || r_tag_out !== 4'(i + 5) || lat !== 2) begin
                tests_failed++; $display("FAIL radix vec%0d: %h tag %h lat %0d required %h tag %h lat 2", i, r_product, r_tag_out, lat, rp[i], 4'(i + 5));
            end
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        tests_run++; if (r_busy !== 1'b0) begin tests_failed++; $display("FAIL radix busy: %b required 0", r_busy); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; multiplicand = '0; multiplier = '0;
        signed_mode = 1'b0; tag_in = '0;
        r_in_valid = 1'b0; r_out_ready = 1'b1; r_mcand = '0; r_mplier = '0;
        r_signed = 1'b0; r_tag_in = '0;
        test_reset();
        test_unsigned();
        test_signed();
        drain();
        test_back_to_back();
        drain();
        test_stall();
        drain();
        test_reset_mid_op();
        test_radix();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
